// File: rtl/gh_pkg.sv
// Shared types and constants for the hit judge / scorer slice.
package gh_pkg;

    typedef enum logic [1:0] {
        ST_COLLECT = 2'd0,
        ST_JUDGE   = 2'd1,
        ST_ADD     = 2'd2
    } state_t;

    localparam int unsigned COMBO_STEP    = 8;
    localparam int unsigned MULT_MAX      = 4;
    localparam logic [15:0] SCORE_MAX_BCD = 16'h9999;

    // Multiplier for a given combo: min(1 + combo/step, mmax).
    function automatic logic [2:0] calc_mult(input logic [7:0]  combo_val,
                                             input int unsigned step,
                                             input int unsigned mmax);
        int unsigned steps;
        steps = 32'(combo_val) / step;
        if (steps + 1 >= mmax)
            return 3'(mmax);
        return 3'(steps + 1);
    endfunction

endpackage

// File: rtl/bcd_counter4.sv
// Four-digit BCD incrementer with synchronous clear, saturating at 9999.
module bcd_counter4
    import gh_pkg::*;
(
    input  logic        clk,
    input  logic        clear,
    input  logic        inc,
    output logic [15:0] value,
    output logic        sat
);

    logic [15:0] value_next;
    logic        carry;

    assign sat = (value == SCORE_MAX_BCD);

    // Ripple a +1 through the decimal digits.
    always_comb begin
        value_next = value;
        carry      = 1'b1;
        for (int unsigned i = 0; i < 4; i++) begin
            if (carry) begin
                if (value[i*4 +: 4] == 4'd9) begin
                    value_next[i*4 +: 4] = '0;
                end else begin
                    value_next[i*4 +: 4] = value[i*4 +: 4] + 4'd1;
                    carry                = 1'b0;
                end
            end
        end
    end

    // Count register; increments at the ceiling are discarded.
    always_ff @(posedge clk) begin
        if (clear)
            value <= '0;
        else if (inc && !sat)
            value <= value_next;
    end

endmodule

// File: rtl/hit_judge_scorer.sv
// Judges key presses against due notes once per game step and accumulates
// a BCD score weighted by a combo-driven multiplier.
module hit_judge_scorer #(
    parameter int unsigned COMBO_STEP = gh_pkg::COMBO_STEP,
    parameter int unsigned MULT_MAX   = gh_pkg::MULT_MAX
) (
    input  logic        CLOCK_50,
    input  logic        RESET_GAME,
    input  logic        tick,
    input  logic [3:0]  note_due,
    input  logic [3:0]  key_n,
    output logic [15:0] score_bcd,
    output logic [7:0]  combo,
    output logic [2:0]  mult,
    output logic        hit_pulse,
    output logic        miss_pulse,
    output logic        overrun
);

    import gh_pkg::*;

    state_t     state, state_n;

    logic [3:0] key_s1, key_s2, key_s3;
    logic [3:0] press;
    logic [3:0] mask;
    logic [3:0] snap_due, snap_mask;
    logic       pend_valid;
    logic [3:0] pend_due, pend_mask;
    logic [2:0] add_cnt;

    logic       take_tick, take_pend, store_pend, drop;
    logic       judge_hit, judge_miss, add_inc;
    logic       score_sat;

    // A press is a synchronised high-to-low transition of key_n.
    assign press = key_s3 & ~key_s2;

    // State register.
    always_ff @(posedge CLOCK_50) begin
        if (RESET_GAME)
            state <= ST_COLLECT;
        else
            state <= state_n;
    end

    // Next state, tick routing and judging decisions.
    // A tick in COLLECT while the pending slot is still full is dropped; the
    // slot is drained on that same edge, which keeps the queue one deep.
    always_comb begin
        state_n    = state;
        take_tick  = 1'b0;
        take_pend  = 1'b0;
        store_pend = 1'b0;
        drop       = 1'b0;
        judge_hit  = 1'b0;
        judge_miss = 1'b0;
        add_inc    = 1'b0;

        if (tick) begin
            if (state == ST_COLLECT && !pend_valid)
                take_tick = 1'b1;
            else if (pend_valid)
                drop = 1'b1;
            else
                store_pend = 1'b1;
        end

        case (state)
            ST_COLLECT: begin
                if (pend_valid) begin
                    take_pend = 1'b1;
                    state_n   = ST_JUDGE;
                end else if (tick) begin
                    state_n   = ST_JUDGE;
                end
            end
            ST_JUDGE: begin
                if (snap_due == 4'b0000 && snap_mask == 4'b0000) begin
                    state_n = ST_COLLECT;
                end else if (snap_mask == snap_due) begin
                    judge_hit = 1'b1;
                    state_n   = ST_ADD;
                end else begin
                    judge_miss = 1'b1;
                    state_n    = ST_COLLECT;
                end
            end
            ST_ADD: begin
                add_inc = 1'b1;
                if (add_cnt == 3'd1)
                    state_n = ST_COLLECT;
            end
            default: state_n = ST_COLLECT;
        endcase
    end

    // Key synchroniser, press window, snapshot/pending slot and combo state.
    always_ff @(posedge CLOCK_50) begin
        if (RESET_GAME) begin
            key_s1     <= '1;
            key_s2     <= '1;
            key_s3     <= '1;
            mask       <= '0;
            snap_due   <= '0;
            snap_mask  <= '0;
            pend_valid <= 1'b0;
            pend_due   <= '0;
            pend_mask  <= '0;
            add_cnt    <= '0;
            combo      <= '0;
            mult       <= 3'd1;
            hit_pulse  <= 1'b0;
            miss_pulse <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            key_s1 <= key_n;
            key_s2 <= key_s1;
            key_s3 <= key_s2;

            // Every tick closes the window, even a dropped one.
            if (tick)
                mask <= press;
            else
                mask <= mask | press;

            if (take_tick) begin
                snap_due  <= note_due;
                snap_mask <= mask;
            end else if (take_pend) begin
                snap_due  <= pend_due;
                snap_mask <= pend_mask;
            end

            if (store_pend) begin
                pend_valid <= 1'b1;
                pend_due   <= note_due;
                pend_mask  <= mask;
            end else if (take_pend) begin
                pend_valid <= 1'b0;
            end

            if (drop)
                overrun <= 1'b1;

            hit_pulse  <= judge_hit;
            miss_pulse <= judge_miss;

            if (judge_hit) begin
                add_cnt <= mult;
                if (combo != 8'hFF)
                    combo <= combo + 8'd1;
            end else if (add_inc) begin
                add_cnt <= add_cnt - 3'd1;
            end

            if (judge_miss) begin
                combo <= '0;
                mult  <= 3'd1;
            end else begin
                mult  <= calc_mult(combo, COMBO_STEP, MULT_MAX);
            end
        end
    end

    bcd_counter4 u_score (
        .clk   (CLOCK_50),
        .clear (RESET_GAME),
        .inc   (add_inc),
        .value (score_bcd),
        .sat   (score_sat)
    );

endmodule

// File: tb/tb_hit_judge_scorer.sv
// Directed bench for hit_judge_scorer: vector table plus multi-cycle sequences.
module tb_hit_judge_scorer;

    logic        CLOCK_50 = 1'b0;
    logic        RESET_GAME;
    logic        tick;
    logic [3:0]  note_due;
    logic [3:0]  key_n;
    logic [15:0] score_bcd;
    logic [7:0]  combo;
    logic [2:0]  mult;
    logic        hit_pulse;
    logic        miss_pulse;
    logic        overrun;

    int n_checks = 0;
    int n_fail   = 0;

    int m_score, m_combo, m_mult;

    typedef struct {
        logic [3:0]  due;
        logic [3:0]  keys;
        logic        hit;
        logic        miss;
        logic [7:0]  combo;
        logic [2:0]  mult;
        logic [15:0] score;
    } vec_t;

    vec_t vecs[8];

    hit_judge_scorer #(.COMBO_STEP(8), .MULT_MAX(4)) dut (
        .CLOCK_50   (CLOCK_50),
        .RESET_GAME (RESET_GAME),
        .tick       (tick),
        .note_due   (note_due),
        .key_n      (key_n),
        .score_bcd  (score_bcd),
        .combo      (combo),
        .mult       (mult),
        .hit_pulse  (hit_pulse),
        .miss_pulse (miss_pulse),
        .overrun    (overrun)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    task automatic cyc(input int n);
        repeat (n) @(posedge CLOCK_50);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic logic [15:0] to_bcd(input int v);
        return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
    endfunction

    // Press keys for one cycle; the edge lands in the mask before returning.
    task automatic key_press(input logic [3:0] keys);
        key_n = ~keys;
        cyc(1);
        key_n = 4'hF;
        cyc(4);
    endtask

    // Tick is sampled at the next edge; returns one step after that edge.
    task automatic fire_tick(input logic [3:0] due);
        note_due = due;
        tick     = 1'b1;
        cyc(1);
        tick     = 1'b0;
    endtask

    task automatic do_reset();
        RESET_GAME = 1'b1;
        cyc(2);
        RESET_GAME = 1'b0;
        m_score = 0;
        m_combo = 0;
        m_mult  = 1;
    endtask

    // One game step checked against the bench model.
    task automatic play(input logic [3:0] due, input logic [3:0] keys, input bit check);
        bit hit, miss;
        hit  = (due != 4'd0) && (keys == due);
        miss = !hit && !(due == 4'd0 && keys == 4'd0);
        if (keys != 4'd0) key_press(keys);
        else cyc(5);
        fire_tick(due);
        cyc(1);
        if (check) begin
            chk("play_hit", 32'(hit_pulse), 32'(hit));
            chk("play_miss", 32'(miss_pulse), 32'(miss));
        end
        if (hit) begin
            m_score = (m_score + m_mult > 9999) ? 9999 : m_score + m_mult;
            m_combo = (m_combo == 255) ? 255 : m_combo + 1;
            m_mult  = (1 + m_combo / 8 > 4) ? 4 : 1 + m_combo / 8;
        end else if (miss) begin
            m_combo = 0;
            m_mult  = 1;
        end
        cyc(6);
        if (check) begin
            chk("play_combo", 32'(combo), 32'(m_combo));
            chk("play_mult", 32'(mult), 32'(m_mult));
            chk("play_score", 32'(score_bcd), 32'(to_bcd(m_score)));
        end
    endtask

    initial begin
        int extra;

        vecs[0] = '{4'b1000, 4'b1000, 1'b1, 1'b0, 8'd1, 3'd1, 16'h0001};
        vecs[1] = '{4'b0100, 4'b0100, 1'b1, 1'b0, 8'd2, 3'd1, 16'h0002};
        vecs[2] = '{4'b0000, 4'b0000, 1'b0, 1'b0, 8'd2, 3'd1, 16'h0002};
        vecs[3] = '{4'b1000, 4'b1001, 1'b0, 1'b1, 8'd0, 3'd1, 16'h0002};
        vecs[4] = '{4'b0011, 4'b0011, 1'b1, 1'b0, 8'd1, 3'd1, 16'h0003};
        vecs[5] = '{4'b0011, 4'b0010, 1'b0, 1'b1, 8'd0, 3'd1, 16'h0003};
        vecs[6] = '{4'b0000, 4'b0100, 1'b0, 1'b1, 8'd0, 3'd1, 16'h0003};
        vecs[7] = '{4'b1111, 4'b1111, 1'b1, 1'b0, 8'd1, 3'd1, 16'h0004};

        RESET_GAME = 1'b1;
        tick       = 1'b0;
        note_due   = 4'b0000;
        key_n      = 4'hF;
        cyc(3);
        RESET_GAME = 1'b0;
        cyc(1);

        chk("rst_score", 32'(score_bcd), 32'h0);
        chk("rst_combo", 32'(combo), 32'd0);
        chk("rst_mult", 32'(mult), 32'd1);
        chk("rst_hit", 32'(hit_pulse), 32'd0);
        chk("rst_miss", 32'(miss_pulse), 32'd0);
        chk("rst_overrun", 32'(overrun), 32'd0);

        // Vector table: press, tick, pulses exactly two cycles after tick.
        foreach (vecs[i]) begin
            if (vecs[i].keys != 4'd0) key_press(vecs[i].keys);
            else cyc(5);
            fire_tick(vecs[i].due);
            chk("vec_hit_early", 32'(hit_pulse), 32'd0);
            chk("vec_miss_early", 32'(miss_pulse), 32'd0);
            cyc(1);
            chk("vec_hit", 32'(hit_pulse), 32'(vecs[i].hit));
            chk("vec_miss", 32'(miss_pulse), 32'(vecs[i].miss));
            cyc(6);
            chk("vec_combo", 32'(combo), 32'(vecs[i].combo));
            chk("vec_mult", 32'(mult), 32'(vecs[i].mult));
            chk("vec_score", 32'(score_bcd), 32'(vecs[i].score));
        end

        // Eight hits reach mult 2; the ninth adds 2.
        do_reset();
        cyc(1);
        for (int i = 0; i < 8; i++) play(4'b1000, 4'b1000, 1'b1);
        chk("c8_combo", 32'(combo), 32'd8);
        chk("c8_mult", 32'(mult), 32'd2);
        play(4'b0001, 4'b0001, 1'b1);
        chk("c9_score", 32'(score_bcd), 32'h0010);

        // Build up to mult 4, then overlap ticks three cycles apart during ADD.
        for (int i = 0; i < 15; i++) play(4'b0010, 4'b0010, 1'b0);
        chk("pre_ovr_mult", 32'(mult), 32'd4);
        key_press(4'b1000);
        fire_tick(4'b1000);
        cyc(1);
        chk("ovr_hit", 32'(hit_pulse), 32'd1);
        cyc(1);
        fire_tick(4'b1000);
        chk("ovr_early", 32'(overrun), 32'd0);
        cyc(2);
        fire_tick(4'b1000);
        chk("ovr_set", 32'(overrun), 32'd1);
        chk("ovr_miss_early", 32'(miss_pulse), 32'd0);
        cyc(1);
        chk("ovr_pend_miss", 32'(miss_pulse), 32'd1);
        chk("ovr_combo", 32'(combo), 32'd0);
        m_score = m_score + 4;
        m_combo = 0;
        m_mult  = 1;
        chk("ovr_score", 32'(score_bcd), 32'(to_bcd(m_score)));
        extra = 0;
        for (int i = 0; i < 10; i++) begin
            cyc(1);
            if (hit_pulse || miss_pulse) extra++;
        end
        chk("ovr_dropped", 32'(extra), 32'd0);
        chk("ovr_sticky", 32'(overrun), 32'd1);

        // Reset in the middle of ADD.
        play(4'b0100, 4'b0100, 1'b1);
        play(4'b0100, 4'b0100, 1'b1);
        key_press(4'b0100);
        fire_tick(4'b0100);
        cyc(1);
        RESET_GAME = 1'b1;
        cyc(1);
        RESET_GAME = 1'b0;
        chk("rst_add_score", 32'(score_bcd), 32'h0);
        chk("rst_add_mult", 32'(mult), 32'd1);
        chk("rst_add_combo", 32'(combo), 32'd0);
        chk("rst_add_hit", 32'(hit_pulse), 32'd0);
        chk("rst_add_ovr", 32'(overrun), 32'd0);
        m_score = 0;
        m_combo = 0;
        m_mult  = 1;
        play(4'b1000, 4'b1000, 1'b1);

        // Ticks and key edges during reset are ignored.
        RESET_GAME = 1'b1;
        key_n      = 4'h0;
        note_due   = 4'b1000;
        tick       = 1'b1;
        cyc(2);
        tick       = 1'b0;
        RESET_GAME = 1'b0;
        key_n      = 4'hF;
        m_score = 0;
        m_combo = 0;
        m_mult  = 1;
        extra = 0;
        for (int i = 0; i < 6; i++) begin
            cyc(1);
            if (hit_pulse || miss_pulse) extra++;
        end
        chk("rst_tick_ignored", 32'(extra), 32'd0);
        play(4'b0000, 4'b0000, 1'b1);

        // Score saturation: climb to 9998, then a mult-4 hit.
        do_reset();
        cyc(1);
        play(4'b1000, 4'b1000, 1'b0);
        play(4'b1000, 4'b1000, 1'b0);
        play(4'b1000, 4'b0000, 1'b0);
        for (int i = 0; i < 24 + 2487; i++) play(4'b0001, 4'b0001, 1'b0);
        chk("sat_pre_score", 32'(score_bcd), 32'h9998);
        chk("sat_pre_mult", 32'(mult), 32'd4);
        key_press(4'b0001);
        fire_tick(4'b0001);
        cyc(1);
        chk("sat_hit", 32'(hit_pulse), 32'd1);
        cyc(1);
        chk("sat_first_inc", 32'(score_bcd), 32'h9999);
        cyc(3);
        fire_tick(4'b1000);
        cyc(1);
        chk("sat_collect_miss", 32'(miss_pulse), 32'd1);
        chk("sat_final_score", 32'(score_bcd), 32'h9999);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/hit_judge_scorer.md
HIT_JUDGE_SCORER -- requirements
Module: hit_judge_scorer

Interface
REQ-001 SHALL expose parameter COMBO_STEP, default 8, consecutive hits per multiplier step.
REQ-002 SHALL expose parameter MULT_MAX, default 4, multiplier ceiling.
REQ-003 CLOCK_50  in  1  sole clock; all state on rising edge.
REQ-004 RESET_GAME  in  1  synchronous, active-high reset.
REQ-005 tick  in  1  one-cycle game-step strobe, aligned to track shift.
REQ-006 note_due  in  4  head bit of each track shifter; bit3 = track1 ... bit0 = track4.
REQ-007 key_n  in  4  raw active-low push buttons; bit3 = track1 ... bit0 = track4.
REQ-008 score_bcd  out  16  four-digit BCD score; digit0 in [3:0].
REQ-009 combo  out  8  consecutive-hit count, binary.
REQ-010 mult  out  3  current multiplier, 1..MULT_MAX.
REQ-011 hit_pulse  out  1  one-cycle strobe per judged hit.
REQ-012 miss_pulse  out  1  one-cycle strobe per judged miss.
REQ-013 overrun  out  1  sticky flag: a step was dropped.

Function
REQ-014 key_n SHALL pass a 2-flop synchroniser; a press is a synchronised 1->0 edge.
REQ-015 Press edges SHALL OR into a 4-bit window mask; held keys add nothing after the first edge.
REQ-016 An edge in the same cycle as tick SHALL go to the next window.
REQ-017 On tick, {note_due, mask} SHALL be snapshotted and mask cleared in that same cycle.
REQ-018 FSM states: COLLECT, JUDGE, ADD.
REQ-019 COLLECT -> JUDGE the cycle after a snapshot is taken.
REQ-020 JUDGE, expected=0 and mask=0: no pulse, no change, -> COLLECT.
REQ-021 JUDGE, mask==expected and expected!=0: hit. Assert hit_pulse, combo+1 (saturates at 255), load add-count = mult (value before the increment), -> ADD.
REQ-022 JUDGE, any other case (missing press or extra press): miss. Assert miss_pulse, combo=0, mult=1, -> COLLECT.
REQ-023 mult SHALL equal min(1 + combo/COMBO_STEP, MULT_MAX), registered, and update the cycle after combo changes.
REQ-024 ADD SHALL increment score_bcd by 1 per cycle, with decimal carry, until add-count reaches 0, then -> COLLECT.
REQ-025 score_bcd SHALL saturate at 9999; increments at 9999 are discarded but still consume their cycles.
REQ-026 A tick arriving outside COLLECT SHALL be stored in a one-deep pending slot and judged right after the return to COLLECT.
REQ-027 A tick while the pending slot is full SHALL be dropped and SHALL set overrun.
REQ-028 Latency SHALL be: tick -> hit_pulse/miss_pulse 2 cycles; score done 2+mult cycles later.

Reset
REQ-029 RESET_GAME SHALL, on a clock edge, clear these to 0: score_bcd, combo, mask, pending, synchronisers (to idle-high), hit_pulse, miss_pulse, overrun.
REQ-030 On the same edge, mult SHALL be set to 1 and the FSM to COLLECT.
REQ-031 Reset asserted mid-ADD SHALL abort the add; no partial carry is retained.
REQ-032 tick and key edges SHALL be ignored while RESET_GAME is high.

Structure
REQ-033 A shared package gh_pkg SHALL hold: FSM state enum, COMBO_STEP, MULT_MAX, SCORE_MAX_BCD (16'h9999).
REQ-034 A single sub-module bcd_counter4 SHALL be used: 4-digit BCD incrementer with inc/sat/clear.

Verification
REQ-035 Reset, then one note on track1 with key_n[3] pressed inside the window, then tick -> hit_pulse at tick+2, combo=1, score_bcd=16'h0001.
REQ-036 8 consecutive single-note hits -> combo=8; mult=2 after 8th; 9th hit adds 2 -> score_bcd=16'h0010.
REQ-037 note_due=4'b1000 with keys 3 and 0 pressed -> miss_pulse, combo=0, mult=1, score unchanged.
REQ-038 Preload score_bcd=16'h9998, hit with mult=4 -> score_bcd=16'h9999, FSM back in COLLECT after 4 ADD cycles.
REQ-039 Ticks three cycles apart during ADD -> second tick pending and judged; third tick dropped; overrun=1.
REQ-040 RESET_GAME pulsed during ADD -> next cycle score=0, mult=1, FSM COLLECT, no pulse.
